sonata_pinmux: RTL and testbench

- Parametrised output-pin multiplexer with register-programmable per-pin source select.
- Break-before-make guard: a pin is idled for GuardCycles before it switches source.
- Includes a synchroniser bank for input pins.
- Sits between peripheral block IOs (GPIO/UART/SPI/I2C/PWM) and the top-level out pins. Generalises the fixed pin numbering in sonata_pkg to runtime-selectable routing.

---
 rtl/sonata_pinmux_pkg.sv | 13 +
 rtl/sonata_pinmux_guard.sv | 76 +++++++
 rtl/sonata_pinmux.sv | 133 +++++++++++++
 tb/tb_sonata_pinmux.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonata_pinmux_pkg.sv
// Shared constants and types for the output pin multiplexer.
package sonata_pinmux_pkg;

    localparam int unsigned OUT_PIN_NUM         = 20;
    localparam int unsigned IN_PIN_NUM          = 8;
    localparam int unsigned PINMUX_SEL_DISABLED = 0;

    typedef enum logic {
        PinActive = 1'b0,
        PinGuard  = 1'b1
    } pinmux_state_e;

endpackage

// File: rtl/sonata_pinmux_guard.sv
// Per-pin select register with break-before-make guard window.
module sonata_pinmux_guard
    import sonata_pinmux_pkg::*;
#(
    parameter int unsigned SelW        = 4,
    parameter int unsigned GuardCycles = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en,
    input  logic [SelW-1:0] wr_sel,
    output logic [SelW-1:0] sel,
    output logic [SelW-1:0] active_sel,
    output logic            guard
);

    localparam int unsigned     CntW     = (GuardCycles > 0) ? $clog2(GuardCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLoad  = (GuardCycles > 0) ? CntW'(GuardCycles - 1) : '0;
    localparam bit              UseGuard = (GuardCycles > 0);

    pinmux_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [SelW-1:0] active_q, active_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= PinActive;
            cnt_q    <= '0;
            sel_q    <= SelW'(PINMUX_SEL_DISABLED);
            active_q <= SelW'(PINMUX_SEL_DISABLED);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            active_q <= active_d;
        end
    end

    // A write during the guard window restarts it, even back to the old source.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        active_d = active_q;
        unique case (state_q)
            PinActive: begin
                if (wr_en && (wr_sel != active_q)) begin
                    sel_d = wr_sel;
                    if (UseGuard) begin
                        state_d = PinGuard;
                        cnt_d   = CntLoad;
                    end else begin
                        active_d = wr_sel;
                    end
                end
            end
            PinGuard: begin
                if (wr_en) begin
                    sel_d = wr_sel;
                    cnt_d = CntLoad;
                end else if (cnt_q == '0) begin
                    active_d = sel_q;
                    state_d  = PinActive;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
        endcase
    end

    assign sel        = sel_q;
    assign active_sel = active_q;
    assign guard      = (state_q == PinGuard);

endmodule

// File: rtl/sonata_pinmux.sv
// Register-programmable output pin mux with guarded source switching and input synchronisers.
module sonata_pinmux
    import sonata_pinmux_pkg::*;
#(
    parameter int unsigned OutPinNum   = OUT_PIN_NUM,
    parameter int unsigned SrcNum      = 8,
    parameter int unsigned InPinNum    = IN_PIN_NUM,
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned GuardCycles = 2,
    parameter logic        IdleValue   = 1'b1,
    localparam int unsigned AddrW      = $clog2(OutPinNum + 1),
    localparam int unsigned SelW       = $clog2(SrcNum + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          reg_req_i,
    input  logic                          reg_we_i,
    input  logic [AddrW-1:0]              reg_addr_i,
    input  logic [SelW-1:0]               reg_wdata_i,
    output logic [31:0]                   reg_rdata_o,
    output logic                          reg_ready_o,
    output logic                          reg_err_o,
    input  logic [OutPinNum*SrcNum-1:0]   src_i,
    output logic [OutPinNum-1:0]          pin_o,
    output logic [OutPinNum-1:0]          pin_oe_o,
    input  logic [InPinNum-1:0]           in_pins_i,
    output logic [InPinNum-1:0]           in_pins_sync_o,
    output logic                          busy_o
);

    localparam int unsigned      PadW       = 1 << SelW;
    localparam logic [AddrW-1:0] StatusAddr = AddrW'(OutPinNum);
    localparam logic [SelW-1:0]  SelMax     = SelW'(SrcNum);

    if (OutPinNum < 1 || OutPinNum > 32) begin : g_bad_out_pin_num
        $error("OutPinNum must be in 1..32");
    end
    if (SyncStages < 2) begin : g_bad_sync_stages
        $error("SyncStages must be at least 2");
    end
    if (SrcNum < 1) begin : g_bad_src_num
        $error("SrcNum must be at least 1");
    end

    logic                 addr_pin;
    logic                 addr_status;
    logic                 wdata_ok;
    logic [SelW-1:0]      pin_sel    [OutPinNum];
    logic [SelW-1:0]      active_sel [OutPinNum];
    logic [OutPinNum-1:0] guard;
    logic [31:0]          rd_data;
    logic                 rd_err;

    assign addr_pin    = (reg_addr_i < StatusAddr);
    assign addr_status = (reg_addr_i == StatusAddr);
    assign wdata_ok    = (reg_wdata_i <= SelMax);

    for (genvar p = 0; p < OutPinNum; p++) begin : g_pin
        logic            wr_en;
        logic            drive;
        logic [PadW-1:0] src_pad;

        assign wr_en = reg_req_i & reg_we_i & wdata_ok & (reg_addr_i == AddrW'(p));

        sonata_pinmux_guard #(
            .SelW        (SelW),
            .GuardCycles (GuardCycles)
        ) u_guard (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_en      (wr_en),
            .wr_sel     (reg_wdata_i),
            .sel        (pin_sel[p]),
            .active_sel (active_sel[p]),
            .guard      (guard[p])
        );

        // Zero-padded so any select value indexes in range; select s picks source s-1.
        assign src_pad     = PadW'(src_i[p*SrcNum +: SrcNum]);
        assign drive       = ~guard[p] & (active_sel[p] != SelW'(PINMUX_SEL_DISABLED));
        assign pin_oe_o[p] = drive;
        assign pin_o[p]    = drive ? src_pad[active_sel[p] - SelW'(1)] : IdleValue;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (addr_pin) begin
            for (int unsigned p = 0; p < OutPinNum; p++) begin
                if (reg_addr_i == AddrW'(p)) begin
                    rd_data = 32'(pin_sel[p]);
                end
            end
            rd_err = reg_we_i & ~wdata_ok;
        end else if (addr_status) begin
            rd_data = 32'(guard);
            rd_err  = reg_we_i;
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_ready_o <= 1'b0;
            reg_err_o   <= 1'b0;
            reg_rdata_o <= '0;
        end else begin
            reg_ready_o <= reg_req_i;
            reg_err_o   <= reg_req_i & rd_err;
            reg_rdata_o <= reg_req_i ? rd_data : '0;
        end
    end

    logic [InPinNum-1:0] sync_q [SyncStages];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SyncStages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_pins_i;
            for (int unsigned i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign in_pins_sync_o = sync_q[SyncStages-1];
    assign busy_o         = |guard;

endmodule

// File: tb/tb_sonata_pinmux.sv
// Bench for sonata_pinmux: directed register table, guard corner sequences, random traffic vs. a reference model.
module tb_sonata_pinmux;

    localparam int NP = 20;
    localparam int NS = 8;
    localparam int NI = 8;
    localparam int G  = 2;
    localparam int SS = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_req, reg_we;
    logic [4:0]      reg_addr;
    logic [3:0]      reg_wdata;
    logic [31:0]     reg_rdata;
    logic            reg_ready, reg_err;
    logic [NP*NS-1:0] src;
    logic [NP-1:0]   pin, pin_oe;
    logic [NI-1:0]   in_pins, in_sync;
    logic            busy;

    logic            reg0_req, reg0_we;
    logic [4:0]      reg0_addr;
    logic [3:0]      reg0_wdata;
    logic [31:0]     reg0_rdata;
    logic            reg0_ready, reg0_err;
    logic [NP-1:0]   pin0, pin0_oe;
    logic [NI-1:0]   in_sync0;
    logic            busy0;

    always #5 clk = ~clk;

    sonata_pinmux u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .reg_req_i      (reg_req),
        .reg_we_i       (reg_we),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_rdata_o    (reg_rdata),
        .reg_ready_o    (reg_ready),
        .reg_err_o      (reg_err),
        .src_i          (src),
        .pin_o          (pin),
        .pin_oe_o       (pin_oe),
        .in_pins_i      (in_pins),
        .in_pins_sync_o (in_sync),
        .busy_o         (busy)
    );

    sonata_pinmux #(.GuardCycles(0)) u_dut0 (
        .clk_i          (clk),
        .rst_i          (rst),
        .reg_req_i      (reg0_req),
        .reg_we_i       (reg0_we),
        .reg_addr_i     (reg0_addr),
        .reg_wdata_i    (reg0_wdata),
        .reg_rdata_o    (reg0_rdata),
        .reg_ready_o    (reg0_ready),
        .reg_err_o      (reg0_err),
        .src_i          (src),
        .pin_o          (pin0),
        .pin_oe_o       (pin0_oe),
        .in_pins_i      (in_pins),
        .in_pins_sync_o (in_sync0),
        .busy_o         (busy0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-pin pending select, live select, and idle cycles still to run.
    int         sel_m  [NP];
    int         act_m  [NP];
    int         left_m [NP];
    logic [NI-1:0] sync_hist[$];
    logic       exp_ready, exp_err, exp_rd_valid;
    logic [31:0] exp_rdata;

    typedef struct {
        logic        we;
        int          addr;
        int          wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            sel_m[p]  = 0;
            act_m[p]  = 0;
            left_m[p] = 0;
        end
        sync_hist = {};
        for (int i = 0; i < SS; i++) sync_hist.push_back('0);
        exp_ready    = 1'b0;
        exp_err      = 1'b0;
        exp_rd_valid = 1'b0;
        exp_rdata    = '0;
    endfunction

    task automatic check_all();
        logic [NP-1:0] e_pin, e_oe;
        logic          e_busy;
        e_busy = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (left_m[p] == 0 && act_m[p] != 0) begin
                e_pin[p] = src[p*NS + act_m[p] - 1];
                e_oe[p]  = 1'b1;
            end else begin
                e_pin[p] = 1'b1;
                e_oe[p]  = 1'b0;
            end
            if (left_m[p] > 0) e_busy = 1'b1;
        end
        check("pin_o", 32'(pin), 32'(e_pin));
        check("pin_oe_o", 32'(pin_oe), 32'(e_oe));
        check("busy_o", 32'(busy), 32'(e_busy));
        check("reg_ready_o", 32'(reg_ready), 32'(exp_ready));
        check("reg_err_o", 32'(reg_err), 32'(exp_err));
        if (exp_rd_valid) check("reg_rdata_o", reg_rdata, exp_rdata);
        check("in_pins_sync_o", 32'(in_sync), 32'(sync_hist[0]));
    endtask

    // One clock: drive the access, advance the model across the edge, compare after the edge.
    task automatic step(input logic req, input logic we, input int addr, input int wd);
        logic wr;
        reg_req   = req;
        reg_we    = we;
        reg_addr  = 5'(addr);
        reg_wdata = 4'(wd);
        exp_ready    = req;
        exp_err      = 1'b0;
        exp_rdata    = '0;
        exp_rd_valid = req && !we;
        if (req) begin
            if (addr < NP) begin
                exp_rdata = 32'(sel_m[addr]);
                exp_err   = we && (wd > NS);
            end else if (addr == NP) begin
                for (int p = 0; p < NP; p++) exp_rdata[p] = (left_m[p] > 0);
                exp_err = we;
            end else begin
                exp_err = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            wr = req && we && (addr == p) && (wd <= NS);
            if (wr) begin
                if (left_m[p] > 0) begin
                    sel_m[p]  = wd;
                    left_m[p] = G;
                end else if (wd != act_m[p]) begin
                    sel_m[p] = wd;
                    if (G > 0) left_m[p] = G;
                    else act_m[p] = wd;
                end
            end else if (left_m[p] > 0) begin
                left_m[p]--;
                if (left_m[p] == 0) act_m[p] = sel_m[p];
            end
        end
        sync_hist.push_back(in_pins);
        while (sync_hist.size() > SS) void'(sync_hist.pop_front());
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_state();
        check("rst pin_o", 32'(pin), 32'(20'hFFFFF));
        check("rst pin_oe_o", 32'(pin_oe), 32'h0);
        check("rst busy_o", 32'(busy), 32'h0);
        check("rst reg_ready_o", 32'(reg_ready), 32'h0);
        check("rst reg_err_o", 32'(reg_err), 32'h0);
        check("rst reg_rdata_o", reg_rdata, 32'h0);
        check("rst in_pins_sync_o", 32'(in_sync), 32'h0);
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        reg_req  = 1'b0;
        reg0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        reg0_req = 1'b0; reg0_we = 1'b0; reg0_addr = '0; reg0_wdata = '0;
        src = '0;
        in_pins = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        tbl[0]  = '{1'b1, 21, 1, 1'b1, 32'h0};
        tbl[1]  = '{1'b1,  0, 9, 1'b1, 32'h0};
        tbl[2]  = '{1'b0,  0, 0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 20, 1, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 25, 0, 1'b1, 32'h0};
        tbl[5]  = '{1'b1,  7, 3, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 20, 0, 1'b0, 32'h80};
        tbl[7]  = '{1'b0,  7, 0, 1'b0, 32'h3};
        tbl[8]  = '{1'b0, 20, 0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1,  7, 8, 1'b0, 32'h0};
        tbl[10] = '{1'b0,  7, 0, 1'b0, 32'h8};
        tbl[11] = '{1'b1,  7, 8, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 20, 0, 1'b0, 32'h80};
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd);
            check($sformatf("tbl%0d ready", i), 32'(reg_ready), 32'h1);
            check($sformatf("tbl%0d err", i), 32'(reg_err), 32'(tbl[i].exp_err));
            if (!tbl[i].we) check($sformatf("tbl%0d rdata", i), reg_rdata, tbl[i].exp_rd);
        end

        for (int i = 0; i < 1500; i++) begin
            int a;
            src     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            in_pins = NI'($urandom());
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 23)) : int'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 10)));
        end

        do_reset();
        in_pins = '0;
        src     = '0;
        for (int a = 0; a < NP; a++) begin
            step(1'b1, 1'b0, a, 0);
            check($sformatf("post-reset read %0d", a), reg_rdata, 32'h0);
        end

        // Pin 3 onto source 2 (bit 25): two idle cycles then follow the source.
        step(1'b1, 1'b1, 3, 2);
        check("sel idle1 pin", 32'(pin[3]), 32'h1);
        check("sel idle1 oe", 32'(pin_oe[3]), 32'h0);
        check("sel idle1 busy", 32'(busy), 32'h1);
        step(1'b0, 1'b0, 0, 0);
        check("sel idle2 pin", 32'(pin[3]), 32'h1);
        check("sel idle2 busy", 32'(busy), 32'h1);
        step(1'b0, 1'b0, 0, 0);
        check("sel drive pin", 32'(pin[3]), 32'h0);
        check("sel drive oe", 32'(pin_oe[3]), 32'h1);
        check("sel drive busy", 32'(busy), 32'h0);
        src[25] = 1'b1;
        step(1'b0, 1'b0, 0, 0);
        check("sel follow pin", 32'(pin[3]), 32'h1);
        src[25] = 1'b0;
        #1;
        check("sel follow comb", 32'(pin[3]), 32'h0);

        // Pin 5: second write restarts the guard; source 4 is bit 43.
        step(1'b1, 1'b1, 5, 1);
        check("rst1 oe", 32'(pin_oe[5]), 32'h0);
        step(1'b1, 1'b1, 5, 4);
        check("rst2 oe", 32'(pin_oe[5]), 32'h0);
        step(1'b1, 1'b0, 20, 0);
        check("rst3 oe", 32'(pin_oe[5]), 32'h0);
        check("restart status", reg_rdata, 32'h20);
        step(1'b0, 1'b0, 0, 0);
        check("restart drive oe", 32'(pin_oe[5]), 32'h1);
        check("restart drive pin", 32'(pin[5]), 32'h0);
        src[43] = 1'b1;
        step(1'b0, 1'b0, 0, 0);
        check("restart src4 pin", 32'(pin[5]), 32'h1);

        in_pins = '0;
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        in_pins[2] = 1'b1;
        step(1'b0, 1'b0, 0, 0);
        check("sync 1 edge", 32'(in_sync[2]), 32'h0);
        step(1'b0, 1'b0, 0, 0);
        check("sync 2 edges", 32'(in_sync[2]), 32'h1);

        // Zero-guard build: select takes effect on the very next cycle.
        src[0]     = 1'b1;
        reg0_req   = 1'b1;
        reg0_we    = 1'b1;
        reg0_addr  = 5'd0;
        reg0_wdata = 4'd1;
        step(1'b0, 1'b0, 0, 0);
        reg0_req = 1'b0;
        check("g0 pin", 32'(pin0[0]), 32'h1);
        check("g0 oe", 32'(pin0_oe[0]), 32'h1);
        check("g0 busy", 32'(busy0), 32'h0);
        check("g0 ready", 32'(reg0_ready), 32'h1);
        check("g0 err", 32'(reg0_err), 32'h0);
        src[0] = 1'b0;
        #1;
        check("g0 follow", 32'(pin0[0]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
